// File: rtl/datamem_arbiter.sv
// Two-port round-robin arbiter in front of the data memory. Each load is tracked until its
// data returns and is routed back to the port that issued it. Each access is checked for size and alignment.
module datamem_arbiter #(
  parameter int ADDR_W   = 64,
  parameter int DATA_W   = 64,
  parameter int READ_LAT = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [1:0]             req,
  input  logic [1:0]             req_we,
  input  logic [1:0][ADDR_W-1:0] req_addr,
  input  logic [1:0][DATA_W-1:0] req_wdata,
  input  logic [1:0][3:0]        req_size,
  output logic [1:0]             gnt,
  output logic [1:0]             rvalid,
  output logic [DATA_W-1:0]      rdata,
  output logic [1:0]             err,
  output logic                   busy,
  output logic [ADDR_W-1:0]      mem_addr,
  output logic                   mem_we,
  output logic                   mem_re,
  output logic [DATA_W-1:0]      mem_wdata,
  output logic [3:0]             mem_size,
  input  logic [DATA_W-1:0]      mem_rdata
);

  typedef enum logic {IDLE, RD_WAIT} state_e;

  localparam logic [2:0] LAT_INIT = 3'(READ_LAT);

  state_e      state_q, state_d;
  logic        last_q, last_d;
  logic        owner_q, owner_d;
  logic [2:0]  lat_cnt_q, lat_cnt_d;
  logic [1:0]  err_rv_q, err_rv_d;

  logic              win;
  logic              legal;
  logic [3:0]        win_size;
  logic [ADDR_W-1:0] win_addr;

  // When both ports request, the port that did not win last time goes first.
  always_comb begin
    win      = req[1] & (~req[0] | ~last_q);
    win_addr = req_addr[win];
    win_size = req_size[win];
    case (win_size)
      4'd1, 4'd2, 4'd4, 4'd8: legal = (win_addr[2:0] & 3'(win_size - 4'd1)) == 3'd0;
      default:                legal = 1'b0;
    endcase
  end

  // NOTE: every output and next-state signal gets a default before the case, so no path leaves one unassigned (no latches).
  always_comb begin
    gnt       = '0;
    err       = '0;
    rvalid    = err_rv_q;
    rdata     = '0;
    busy      = 1'b0;
    mem_addr  = '0;
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    mem_wdata = '0;
    mem_size  = '0;
    state_d   = state_q;
    last_d    = last_q;
    owner_d   = owner_q;
    lat_cnt_d = lat_cnt_q;
    err_rv_d  = '0;

    unique case (state_q)
      IDLE: begin
        if (req != 2'b00) begin
          gnt[win]  = 1'b1;
          last_d    = win;
          mem_addr  = win_addr;
          mem_wdata = req_wdata[win];
          mem_size  = win_size;
          if (!legal) begin
            // A rejected load still gets a response, with zero data, on the next cycle.
            err[win]      = 1'b1;
            err_rv_d[win] = ~req_we[win];
          end else if (req_we[win]) begin
            mem_we = 1'b1;
          end else begin
            mem_re    = 1'b1;
            owner_d   = win;
            lat_cnt_d = LAT_INIT;
            state_d   = RD_WAIT;
          end
        end
      end
      RD_WAIT: begin
        busy      = 1'b1;
        lat_cnt_d = lat_cnt_q - 3'd1;
        if (lat_cnt_q == 3'd1) begin
          rvalid[owner_q] = 1'b1;
          rdata           = mem_rdata;
          state_d         = IDLE;
        end
      end
    endcase

    // The grant path is combinational from req, so it is gated here to keep every output low while reset is asserted.
    if (!reset) begin
      gnt       = '0;
      err       = '0;
      mem_addr  = '0;
      mem_we    = 1'b0;
      mem_re    = 1'b0;
      mem_wdata = '0;
      mem_size  = '0;
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the clock edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      last_q    <= 1'b1;
      owner_q   <= 1'b0;
      lat_cnt_q <= 3'd0;
      err_rv_q  <= 2'b00;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      owner_q   <= owner_d;
      lat_cnt_q <= lat_cnt_d;
      err_rv_q  <= err_rv_d;
    end
  end

endmodule

// File: tb/tb_datamem_arbiter.sv
// Bench for datamem_arbiter. It runs a vector table, directed sequences for reset, load latency and load abort,
// and random traffic that is compared against a transaction-level reference model.
module tb_datamem_arbiter;

  localparam int AW  = 64;
  localparam int DW  = 64;
  localparam int RL  = 3;
  localparam int RL4 = 4;
  localparam logic [63:0] WD0 = 64'h1111_2222_3333_4444;
  localparam logic [63:0] WD1 = 64'hAAAA_BBBB_CCCC_DDDD;

  logic                clk = 1'b0;
  logic                reset = 1'b0;
  logic [1:0]          req, req_we;
  logic [1:0][AW-1:0]  req_addr;
  logic [1:0][DW-1:0]  req_wdata;
  logic [1:0][3:0]     req_size;

  logic [1:0]    gnt, rvalid, err;
  logic [DW-1:0] rdata;
  logic          busy;
  logic [AW-1:0] mem_addr;
  logic          mem_we, mem_re;
  logic [DW-1:0] mem_wdata;
  logic [3:0]    mem_size;
  logic [DW-1:0] mem_rdata;

  logic [1:0]    gnt_4, rvalid_4, err_4;
  logic [DW-1:0] rdata_4;
  logic          busy_4;
  logic [AW-1:0] mem_addr_4;
  logic          mem_we_4, mem_re_4;
  logic [DW-1:0] mem_wdata_4;
  logic [3:0]    mem_size_4;
  logic [DW-1:0] mem_rdata_4;

  always #5 clk = ~clk;

  datamem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .READ_LAT(RL)) dut (
    .clk(clk), .reset(reset), .req(req), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_size(req_size), .gnt(gnt), .rvalid(rvalid), .rdata(rdata),
    .err(err), .busy(busy), .mem_addr(mem_addr), .mem_we(mem_we), .mem_re(mem_re),
    .mem_wdata(mem_wdata), .mem_size(mem_size), .mem_rdata(mem_rdata)
  );

  datamem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .READ_LAT(RL4)) dut4 (
    .clk(clk), .reset(reset), .req(req), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_size(req_size), .gnt(gnt_4), .rvalid(rvalid_4), .rdata(rdata_4),
    .err(err_4), .busy(busy_4), .mem_addr(mem_addr_4), .mem_we(mem_we_4), .mem_re(mem_re_4),
    .mem_wdata(mem_wdata_4), .mem_size(mem_size_4), .mem_rdata(mem_rdata_4)
  );

  // Memory model: data is a fixed function of the address and appears RL cycles after mem_re.
  function automatic logic [63:0] memf(input logic [63:0] a);
    if (a == 64'h20) return 64'h0000_0000_DEAD_BEEF;
    return {~a[31:0], a[31:0]} ^ 64'h0F0F_0F0F_0F0F_0F0F;
  endfunction

  logic [AW-1:0] pipe [RL];
  always @(posedge clk) begin
    pipe[0] <= mem_re ? mem_addr : '0;
    for (int i = 1; i < RL; i++) pipe[i] <= pipe[i-1];
  end
  assign mem_rdata   = memf(pipe[RL-1]);
  assign mem_rdata_4 = 64'h4444_0000_0000_4444;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    req   = 2'b00;
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b1;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [1:0]  req, we;
    logic [63:0] a0, a1;
    logic [3:0]  s0, s1;
    logic [1:0]  gnt, err, rv;
    logic        mwe, mre;
    logic [63:0] maddr;
    logic [3:0]  msize;
  } vec_t;

  function automatic vec_t mk(input logic [1:0] rq, input logic [1:0] we,
                              input logic [63:0] a0, input logic [3:0] s0,
                              input logic [63:0] a1, input logic [3:0] s1,
                              input logic [1:0] g, input logic [1:0] e, input logic [1:0] rv,
                              input logic mwe, input logic mre,
                              input logic [63:0] maddr, input logic [3:0] msize);
    vec_t v;
    v.req = rq; v.we = we; v.a0 = a0; v.s0 = s0; v.a1 = a1; v.s1 = s1;
    v.gnt = g; v.err = e; v.rv = rv; v.mwe = mwe; v.mre = mre; v.maddr = maddr; v.msize = msize;
    return v;
  endfunction

  typedef struct {
    int          due;
    logic        port;
    logic [63:0] data;
  } resp_t;

  vec_t  vecs[$];
  resp_t rq[$];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [3:0] sz_tab [10] = '{4'd1, 4'd2, 4'd4, 4'd8, 4'd1, 4'd2, 4'd4, 4'd8, 4'd3, 4'd12};
    int         cyc, blocked;
    logic       last, g, w, ok;
    logic [1:0] exp_rv;
    logic [63:0] exp_rd;
    resp_t      r;

    req = '0; req_we = '0; req_addr = '0; req_size = '0;
    req_wdata[0] = WD0;
    req_wdata[1] = WD1;

    // Vector table; reset leaves last=1, so the first tie goes to port 0.
    vecs.push_back(mk(2'b11, 2'b11, 64'h10, 4'd8, 64'h18, 4'd8, 2'b01, 2'b00, 2'b00, 1, 0, 64'h10, 4'd8));
    vecs.push_back(mk(2'b11, 2'b11, 64'h10, 4'd8, 64'h18, 4'd8, 2'b10, 2'b00, 2'b00, 1, 0, 64'h18, 4'd8));
    vecs.push_back(mk(2'b11, 2'b11, 64'h10, 4'd8, 64'h18, 4'd8, 2'b01, 2'b00, 2'b00, 1, 0, 64'h10, 4'd8));
    vecs.push_back(mk(2'b11, 2'b11, 64'h10, 4'd8, 64'h18, 4'd8, 2'b10, 2'b00, 2'b00, 1, 0, 64'h18, 4'd8));
    vecs.push_back(mk(2'b01, 2'b00, 64'h13, 4'd4, 64'h0,  4'd8, 2'b01, 2'b01, 2'b00, 0, 0, 64'h13, 4'd4));
    vecs.push_back(mk(2'b01, 2'b00, 64'h10, 4'd3, 64'h0,  4'd8, 2'b01, 2'b01, 2'b01, 0, 0, 64'h10, 4'd3));
    vecs.push_back(mk(2'b01, 2'b01, 64'h7,  4'd1, 64'h0,  4'd8, 2'b01, 2'b00, 2'b01, 1, 0, 64'h7,  4'd1));
    vecs.push_back(mk(2'b00, 2'b00, 64'h0,  4'd8, 64'h0,  4'd8, 2'b00, 2'b00, 2'b00, 0, 0, 64'h0,  4'd0));
    vecs.push_back(mk(2'b10, 2'b10, 64'h0,  4'd8, 64'h6,  4'd2, 2'b10, 2'b00, 2'b00, 1, 0, 64'h6,  4'd2));
    vecs.push_back(mk(2'b11, 2'b11, 64'h8,  4'd4, 64'h3,  4'd1, 2'b01, 2'b00, 2'b00, 1, 0, 64'h8,  4'd4));
    vecs.push_back(mk(2'b11, 2'b11, 64'h8,  4'd4, 64'h4,  4'd8, 2'b10, 2'b10, 2'b00, 0, 0, 64'h4,  4'd8));
    vecs.push_back(mk(2'b10, 2'b00, 64'h0,  4'd8, 64'h1,  4'd0, 2'b10, 2'b10, 2'b00, 0, 0, 64'h1,  4'd0));
    vecs.push_back(mk(2'b00, 2'b00, 64'h0,  4'd8, 64'h0,  4'd8, 2'b00, 2'b00, 2'b10, 0, 0, 64'h0,  4'd0));
    vecs.push_back(mk(2'b01, 2'b01, 64'hFFFF_0000_1234_5678, 4'd8, 64'h0, 4'd8,
                      2'b01, 2'b00, 2'b00, 1, 0, 64'hFFFF_0000_1234_5678, 4'd8));

    do_reset();
    check("reset gnt", gnt, 2'b00);
    check("reset busy", busy, 1'b0);
    check("reset rvalid", rvalid, 2'b00);

    foreach (vecs[i]) begin
      req = vecs[i].req; req_we = vecs[i].we;
      req_addr[0] = vecs[i].a0; req_addr[1] = vecs[i].a1;
      req_size[0] = vecs[i].s0; req_size[1] = vecs[i].s1;
      @(negedge clk);
      check($sformatf("v%0d gnt", i), gnt, vecs[i].gnt);
      check($sformatf("v%0d err", i), err, vecs[i].err);
      check($sformatf("v%0d rvalid", i), rvalid, vecs[i].rv);
      check($sformatf("v%0d mem_we", i), mem_we, vecs[i].mwe);
      check($sformatf("v%0d mem_re", i), mem_re, vecs[i].mre);
      check($sformatf("v%0d busy", i), busy, 1'b0);
      if (vecs[i].gnt != 2'b00) begin
        check($sformatf("v%0d mem_addr", i), mem_addr, vecs[i].maddr);
        check($sformatf("v%0d mem_size", i), mem_size, vecs[i].msize);
      end
      if (vecs[i].mwe) check($sformatf("v%0d mem_wdata", i), mem_wdata, vecs[i].gnt[1] ? WD1 : WD0);
      if (vecs[i].rv != 2'b00) check($sformatf("v%0d rdata", i), rdata, 64'h0);
      next_cycle();
    end

    // Mid-simulation reset: outputs drop at once, and the tie-break pointer returns to port 0.
    req = 2'b01; req_we = 2'b11; req_addr[0] = 64'h10; req_size[0] = 4'd8;
    req_addr[1] = 64'h18; req_size[1] = 4'd8;
    @(negedge clk);
    check("rst pre gnt", gnt, 2'b01);
    next_cycle();
    req = 2'b11;
    #2 reset = 1'b0;
    #1;
    check("rst gnt", gnt, 2'b00);
    check("rst mem_we", mem_we, 1'b0);
    check("rst mem_addr", mem_addr, 64'h0);
    check("rst mem_size", mem_size, 4'd0);
    check("rst mem_wdata", mem_wdata, 64'h0);
    check("rst busy", busy, 1'b0);
    check("rst err", err, 2'b00);
    check("rst rvalid", rvalid, 2'b00);
    next_cycle();
    reset = 1'b1;
    @(negedge clk);
    check("rst post tie gnt", gnt, 2'b01);
    next_cycle();

    // Port 1 load with latency 3; port 0 keeps requesting while the load is outstanding.
    req = 2'b10; req_we = 2'b00; req_addr[1] = 64'h20; req_size[1] = 4'd8;
    @(negedge clk);
    check("ld gnt", gnt, 2'b10);
    check("ld mem_re", mem_re, 1'b1);
    check("ld mem_addr", mem_addr, 64'h20);
    check("ld busy t", busy, 1'b0);
    next_cycle();
    req = 2'b01; req_we = 2'b01; req_addr[0] = 64'h30; req_size[0] = 4'd8;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (k <= 3) begin
        check($sformatf("ld t+%0d busy", k), busy, 1'b1);
        check($sformatf("ld t+%0d gnt", k), gnt, 2'b00);
        check($sformatf("ld t+%0d mem_we", k), mem_we, 1'b0);
        check($sformatf("ld t+%0d mem_re", k), mem_re, 1'b0);
        check($sformatf("ld t+%0d rvalid", k), rvalid, (k == 3) ? 2'b10 : 2'b00);
        if (k == 3) check("ld rdata", rdata, 64'hDEAD_BEEF);
      end else begin
        check("ld t+4 gnt", gnt, 2'b01);
        check("ld t+4 busy", busy, 1'b0);
        check("ld t+4 mem_we", mem_we, 1'b1);
      end
      next_cycle();
    end

    // Reset two cycles into a latency-4 load: the load is aborted and never returns.
    do_reset();
    req = 2'b01; req_we = 2'b00; req_addr[0] = 64'h28; req_size[0] = 4'd8;
    @(negedge clk);
    check("abort gnt", gnt_4, 2'b01);
    check("abort mem_re", mem_re_4, 1'b1);
    check("abort mem_addr", mem_addr_4, 64'h28);
    next_cycle();
    req = 2'b00;
    @(negedge clk);
    check("abort t+1 busy", busy_4, 1'b1);
    next_cycle();
    @(negedge clk);
    check("abort t+2 busy", busy_4, 1'b1);
    #1 reset = 1'b0;
    #1;
    check("abort rst gnt", gnt_4, 2'b00);
    check("abort rst rvalid", rvalid_4, 2'b00);
    check("abort rst err", err_4, 2'b00);
    check("abort rst rdata", rdata_4, 64'h0);
    check("abort rst busy", busy_4, 1'b0);
    check("abort rst mem_addr", mem_addr_4, 64'h0);
    check("abort rst mem_we", mem_we_4, 1'b0);
    check("abort rst mem_re", mem_re_4, 1'b0);
    check("abort rst mem_wdata", mem_wdata_4, 64'h0);
    check("abort rst mem_size", mem_size_4, 4'd0);
    @(posedge clk);
    next_cycle();
    reset = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check($sformatf("abort idle%0d rvalid", k), rvalid_4, 2'b00);
      check($sformatf("abort idle%0d busy", k), busy_4, 1'b0);
      next_cycle();
    end
    req = 2'b11; req_we = 2'b11; req_addr[0] = 64'h40; req_addr[1] = 64'h48;
    req_size[0] = 4'd8; req_size[1] = 4'd8;
    @(negedge clk);
    check("abort new gnt", gnt_4, 2'b01);
    check("abort new err", err_4, 2'b00);
    check("abort new mem_we", mem_we_4, 1'b1);
    check("abort new mem_addr", mem_addr_4, 64'h40);
    check("abort new mem_size", mem_size_4, 4'd8);
    check("abort new mem_wdata", mem_wdata_4, WD0);
    next_cycle();

    // Random traffic against a transaction-level model: a blocked-cycle budget, a tie pointer and a response queue.
    do_reset();
    cyc = 0; blocked = 0; last = 1'b1;
    rq.delete();
    for (int n = 0; n < 600; n++) begin
      for (int p = 0; p < 2; p++) begin
        if (req[p] && $urandom_range(15) == 0) begin
          req[p] = 1'b0;
        end else if (req[p] && $urandom_range(7) == 0) begin
          req_wdata[p] = {$urandom, $urandom};
        end else if (!req[p] && $urandom_range(1) == 1) begin
          logic [3:0]  sz;
          logic [63:0] a;
          sz = sz_tab[$urandom_range(0, 9)];
          a  = {$urandom, $urandom};
          if ((sz == 1 || sz == 2 || sz == 4 || sz == 8) && $urandom_range(3) != 0)
            a = a - (a % 64'(sz));
          req[p] = 1'b1;
          req_we[p] = 1'($urandom_range(1));
          req_addr[p] = a;
          req_size[p] = sz;
          req_wdata[p] = {$urandom, $urandom};
        end
      end

      @(negedge clk);
      exp_rv = 2'b00;
      exp_rd = '0;
      foreach (rq[i]) begin
        if (rq[i].due == cyc) begin
          exp_rv[rq[i].port] = 1'b1;
          exp_rd = rq[i].data;
        end
      end
      g = 1'b0; w = 1'b0; ok = 1'b0;
      if (blocked == 0 && req != 2'b00) begin
        g  = 1'b1;
        w  = (req == 2'b11) ? !last : req[1];
        ok = (req_size[w] == 1 || req_size[w] == 2 || req_size[w] == 4 || req_size[w] == 8) &&
             (req_addr[w] % 64'(req_size[w]) == 0);
      end
      check("rnd gnt", gnt, g ? (2'b01 << w) : 2'b00);
      check("rnd err", err, (g && !ok) ? (2'b01 << w) : 2'b00);
      check("rnd mem_we", mem_we, g && ok && req_we[w]);
      check("rnd mem_re", mem_re, g && ok && !req_we[w]);
      check("rnd busy", busy, blocked > 0);
      check("rnd rvalid", rvalid, exp_rv);
      if (exp_rv != 2'b00) check("rnd rdata", rdata, exp_rd);
      if (g) begin
        check("rnd mem_addr", mem_addr, req_addr[w]);
        check("rnd mem_size", mem_size, req_size[w]);
        if (ok && req_we[w]) check("rnd mem_wdata", mem_wdata, req_wdata[w]);
      end

      @(posedge clk);
      if (blocked > 0) begin
        blocked--;
      end else if (g) begin
        last = w;
        if (!req_we[w]) begin
          r.port = w;
          r.due  = ok ? cyc + RL : cyc + 1;
          r.data = ok ? memf(req_addr[w]) : 64'h0;
          rq.push_back(r);
          if (ok) blocked = RL;
        end
      end
      while (rq.size() > 0 && rq[0].due <= cyc) void'(rq.pop_front());
      cyc++;
      #1;
      if (g) req[w] = 1'b0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
